// File: rtl/fp_align_addsub.sv
// Align/add/normalise stage of the FP add/sub datapath: serial right-shift alignment,
// single-cycle magnitude add or subtract, then serial left-shift normalisation.
module fp_align_addsub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] big_mant,
  input  logic [3:0] small_mant,
  input  logic [3:0] big_exp,
  input  logic [3:0] exp_diff,
  input  logic       big_sign,
  input  logic       eff_sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] res_mant,
  output logic [3:0] res_exp,
  output logic       res_sign,
  output logic       res_zero,
  output logic       ovf,
  output logic [2:0] dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // once valid is raised it stays high with stable data until that transfer.
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] big_q, small_q, bexp_q;
  logic       sign_q, sub_q;
  logic [2:0] cnt_q;

  logic [4:0] sum;
  logic [3:0] as_mant, as_exp, norm_mant, norm_exp;
  logic       as_ovf, as_zero, accept, handshake;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign dbg_state = state_q;

  always_comb begin
    sum     = {1'b0, big_q} + {1'b0, small_q};
    as_mant = 4'd0;
    as_exp  = bexp_q;
    as_ovf  = 1'b0;
    if (sub_q) begin
      as_mant = big_q - small_q;
    end else if (sum[4]) begin
      if (bexp_q == 4'hF) begin
        // Carry out of the largest exponent saturates instead of wrapping.
        as_mant = 4'hF;
        as_ovf  = 1'b1;
      end else begin
        as_mant = sum[4:1];
        as_exp  = bexp_q + 4'd1;
      end
    end else begin
      as_mant = sum[3:0];
    end
    as_zero   = (as_mant == 4'd0);
    norm_mant = {res_mant[2:0], 1'b0};
    norm_exp  = res_exp - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (exp_diff != 4'd0) ? S_ALIGN : S_ADDSUB;
      S_ALIGN:  if (cnt_q == 3'd1) state_d = S_ADDSUB;
      S_ADDSUB: state_d = (as_zero || as_mant[3] || as_exp == 4'd0) ? S_DONE : S_NORM;
      S_NORM:   if (norm_mant[3] || norm_exp == 4'd0) state_d = S_DONE;
      S_DONE:   if (handshake) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_q     <= 4'd0;
      small_q   <= 4'd0;
      bexp_q    <= 4'd0;
      sign_q    <= 1'b0;
      sub_q     <= 1'b0;
      cnt_q     <= 3'd0;
      res_mant  <= 4'd0;
      res_exp   <= 4'd0;
      res_sign  <= 1'b0;
      res_zero  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          big_q    <= big_mant;
          small_q  <= small_mant;
          bexp_q   <= big_exp;
          sign_q   <= big_sign;
          sub_q    <= eff_sub;
          cnt_q    <= (exp_diff >= 4'd4) ? 3'd4 : exp_diff[2:0];
          res_zero <= 1'b0;
          ovf      <= 1'b0;
        end
        S_ALIGN: begin
          small_q <= small_q >> 1;
          cnt_q   <= cnt_q - 3'd1;
        end
        S_ADDSUB: begin
          res_mant <= as_zero ? 4'd0 : as_mant;
          res_exp  <= as_zero ? 4'd0 : as_exp;
          res_sign <= as_zero ? 1'b0 : sign_q;
          res_zero <= as_zero;
          ovf      <= as_ovf;
        end
        S_NORM: begin
          res_mant <= norm_mant;
          res_exp  <= norm_exp;
        end
        default: ;
      endcase
      // Result registers settle on DONE entry; valid is presented from the following cycle.
      out_valid <= (state_q == S_DONE) && !handshake;
    end
  end

endmodule
